// File: rtl/am_insertion_scheduler_pkg.sv
// rtl/am_insertion_scheduler_pkg.sv - shared AM period defaults and scheduler state type
package am_insertion_scheduler_pkg;

    localparam int BITS_BLOCK_DEF    = 257;
    localparam int MAX_BLOCKS_AM_DEF = 40;
    localparam int AM_BLOCKS_DEF     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AM   = 2'd1,
        ST_DATA = 2'd2
    } sched_state_t;

    // Index fields stay at least one bit wide so single-entry counts still elaborate.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/am_insertion_scheduler_if.sv
// rtl/am_insertion_scheduler_if.sv - payload/AM input and scheduled block output bundle
interface am_insertion_scheduler_if
    import am_insertion_scheduler_pkg::*;
#(
    parameter int BITS_BLOCK    = BITS_BLOCK_DEF,
    parameter int MAX_BLOCKS_AM = MAX_BLOCKS_AM_DEF,
    parameter int AM_BLOCKS     = AM_BLOCKS_DEF
) ();
    localparam int AM_IDX_W  = idx_width(AM_BLOCKS);
    localparam int BLK_IDX_W = idx_width(MAX_BLOCKS_AM);

    logic                  i_enable;
    logic [BITS_BLOCK-1:0] i_am_block;
    logic [BITS_BLOCK-1:0] i_data;
    logic                  i_data_valid;
    logic                  o_data_ready;
    logic [BITS_BLOCK-1:0] o_block;
    logic                  o_block_valid;
    logic                  i_block_ready;
    logic [AM_IDX_W-1:0]   o_am_idx;
    logic [BLK_IDX_W-1:0]  o_block_idx;
    logic                  o_is_am;
    logic                  o_period_start;
    logic                  o_underrun;

    modport master (
        input  i_enable, i_am_block, i_data, i_data_valid, i_block_ready,
        output o_data_ready, o_block, o_block_valid, o_am_idx, o_block_idx,
               o_is_am, o_period_start, o_underrun
    );

    modport slave (
        output i_enable, i_am_block, i_data, i_data_valid, i_block_ready,
        input  o_data_ready, o_block, o_block_valid, o_am_idx, o_block_idx,
               o_is_am, o_period_start, o_underrun
    );

endinterface

// File: rtl/am_insertion_scheduler_counter.sv
// rtl/am_insertion_scheduler_counter.sv - block position and AM slice counters for one AM period
module am_period_counter
    import am_insertion_scheduler_pkg::*;
#(
    parameter int MAX_BLOCKS_AM = MAX_BLOCKS_AM_DEF,
    parameter int AM_BLOCKS     = AM_BLOCKS_DEF,
    localparam int BW = idx_width(MAX_BLOCKS_AM),
    localparam int AW = idx_width(AM_BLOCKS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          adv,
    input  logic          am_adv,
    output logic [BW-1:0] block_idx,
    output logic [AW-1:0] am_idx,
    output logic          last_block,
    output logic          last_am
);

    assign last_block = (block_idx == BW'(MAX_BLOCKS_AM - 1));
    assign last_am    = (am_idx == AW'(AM_BLOCKS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            block_idx <= '0;
            am_idx    <= '0;
        end else if (adv) begin
            if (last_block) begin
                block_idx <= '0;
                am_idx    <= '0;
            end else begin
                block_idx <= block_idx + BW'(1);
                if (am_adv) begin
                    am_idx <= last_am ? '0 : am_idx + AW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/am_insertion_scheduler.sv
// rtl/am_insertion_scheduler.sv - inserts AM blocks at a fixed period into the transcoded block stream
module am_insertion_scheduler
    import am_insertion_scheduler_pkg::*;
#(
    parameter int BITS_BLOCK    = BITS_BLOCK_DEF,
    parameter int MAX_BLOCKS_AM = MAX_BLOCKS_AM_DEF,
    parameter int AM_BLOCKS     = AM_BLOCKS_DEF
) (
    input  logic clk,
    input  logic rst,
    am_insertion_scheduler_if.master bus
);
    localparam int AW = idx_width(AM_BLOCKS);
    localparam int BW = idx_width(MAX_BLOCKS_AM);

    sched_state_t  state, state_nxt;
    logic          load;
    logic          data_ready;
    logic          last_block;
    logic          last_am;
    logic [AW-1:0] am_idx;
    logic [BW-1:0] block_idx;

    am_period_counter #(
        .MAX_BLOCKS_AM (MAX_BLOCKS_AM),
        .AM_BLOCKS     (AM_BLOCKS)
    ) u_period_counter (
        .clk        (clk),
        .rst        (rst),
        .adv        (load),
        .am_adv     (state == ST_AM),
        .block_idx  (block_idx),
        .am_idx     (am_idx),
        .last_block (last_block),
        .last_am    (last_am)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        data_ready = 1'b0;
        load       = (state != ST_IDLE) && (!bus.o_block_valid || bus.i_block_ready);
        case (state)
            ST_IDLE: begin
                if (bus.i_enable) begin
                    state_nxt = ST_AM;
                end
            end
            ST_AM: begin
                if (load && last_block) begin
                    state_nxt = bus.i_enable ? ST_AM : ST_IDLE;
                end else if (load && last_am) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                data_ready = load && bus.i_data_valid;
                // Enable is only consulted at the period boundary, so a stop never truncates a period.
                if (load && last_block) begin
                    state_nxt = bus.i_enable ? ST_AM : ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.o_block        <= '0;
            bus.o_block_valid  <= 1'b0;
            bus.o_is_am        <= 1'b0;
            bus.o_period_start <= 1'b0;
            bus.o_underrun     <= 1'b0;
        end else begin
            bus.o_period_start <= load && (state == ST_AM) && (am_idx == '0);
            bus.o_underrun     <= load && (state == ST_DATA) && !bus.i_data_valid;
            if (load) begin
                bus.o_block_valid <= 1'b1;
                if (state == ST_AM) begin
                    bus.o_block <= bus.i_am_block;
                    bus.o_is_am <= 1'b1;
                end else if (bus.i_data_valid) begin
                    bus.o_block <= bus.i_data;
                    bus.o_is_am <= 1'b0;
                end else begin
                    // Fill keeps the slot occupied so the AM spacing never drifts.
                    bus.o_block <= '1;
                    bus.o_is_am <= 1'b0;
                end
            end else if (bus.i_block_ready) begin
                bus.o_block_valid <= 1'b0;
            end
        end
    end

    assign bus.o_data_ready = data_ready;
    assign bus.o_am_idx     = am_idx;
    assign bus.o_block_idx  = block_idx;

endmodule

// File: tb/tb_am_insertion_scheduler.sv
// tb/tb_am_insertion_scheduler.sv - scoreboard bench for am_insertion_scheduler
module tb_am_insertion_scheduler;
    import am_insertion_scheduler_pkg::*;

    localparam int BB = 257;
    localparam int NA = 40;
    localparam int KA = 4;
    localparam int NB = 8;

    typedef logic [BB-1:0] blk_t;
    typedef struct {
        blk_t blk;
        bit   is_am;
        bit   ps;
        bit   ur;
        int   slot;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    am_insertion_scheduler_if #(.BITS_BLOCK(BB), .MAX_BLOCKS_AM(NA), .AM_BLOCKS(KA)) ifa ();
    am_insertion_scheduler_if #(.BITS_BLOCK(BB), .MAX_BLOCKS_AM(NB), .AM_BLOCKS(KA)) ifb ();

    am_insertion_scheduler #(.BITS_BLOCK(BB), .MAX_BLOCKS_AM(NA), .AM_BLOCKS(KA)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.master)
    );

    am_insertion_scheduler #(.BITS_BLOCK(BB), .MAX_BLOCKS_AM(NB), .AM_BLOCKS(KA)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.master)
    );

    int   total = 0;
    int   bad = 0;
    exp_t expq[$];
    bit   drop[0:7][0:NA-1];
    int   pushed_per = 0;
    int   pcount = 0;
    int   exp_pay = 0;
    int   src_cnt = 0;
    int   srcb = 0;
    int   stall = 0;
    bit   chk_b = 0;

    function automatic blk_t am_pat(input int i);
        return {1'b1, {8{32'hA3C5_0F00 ^ 32'(i)}}};
    endfunction

    function automatic blk_t pay(input int n);
        return {1'b0, {8{32'h5A00_0000 + 32'(n)}}};
    endfunction

    task automatic chk_blk(input string name, input blk_t act, input blk_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    // Environment: AM mapper answers the requested slice, payload source holds its head until taken.
    assign ifa.i_am_block   = am_pat(int'(ifa.o_am_idx));
    assign ifa.i_data       = pay(src_cnt);
    assign ifa.i_data_valid = (pcount > 0 && pcount <= 8) ? !drop[pcount-1][ifa.o_block_idx] : 1'b1;
    assign ifb.i_am_block   = am_pat(int'(ifb.o_am_idx));
    assign ifb.i_data       = pay(srcb);
    assign ifb.i_data_valid = 1'b1;
    assign ifb.i_block_ready = 1'b1;

    task automatic push_period(input bit fixed);
        int g;
        exp_t e;
        g = pushed_per;
        pushed_per++;
        for (int s = 0; s < NA; s++) begin
            drop[g][s] = (s >= KA) && (fixed ? (s >= 10 && s <= 12) : ($urandom_range(0, 6) == 0));
            e.slot = s;
            e.is_am = (s < KA);
            e.ps = (s == 0);
            e.ur = 1'b0;
            if (s < KA) begin
                e.blk = am_pat(s);
            end else if (drop[g][s]) begin
                e.blk = '1;
                e.ur = 1'b1;
            end else begin
                e.blk = pay(exp_pay);
                exp_pay++;
            end
            expq.push_back(e);
        end
    endtask

    initial begin
        bit acc, accb;
        ifa.i_block_ready = 1'b0;
        forever begin
            @(negedge clk);
            acc  = ifa.o_data_ready && ifa.i_data_valid;
            accb = ifb.o_data_ready;
            @(posedge clk);
            #1;
            if (acc) src_cnt++;
            if (accb) srcb++;
            if (stall > 0) begin
                ifa.i_block_ready = 1'b0;
                stall--;
            end else begin
                ifa.i_block_ready = ($urandom_range(0, 9) < 8);
            end
        end
    end

    initial begin
        bit   prev_v, prev_r, first;
        blk_t prev_blk;
        int   prev_bi, prev_ai;
        exp_t e;
        prev_v = 0; prev_r = 0; prev_blk = '0; prev_bi = 0; prev_ai = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_v = 0;
                prev_r = 0;
            end else begin
                first = ifa.o_block_valid && (!prev_v || prev_r);
                if (ifa.o_period_start) pcount++;
                if (prev_v && !prev_r) begin
                    chk_blk("hold_block", ifa.o_block, prev_blk);
                    chk_i("hold_block_idx", int'(ifa.o_block_idx), prev_bi);
                    chk_i("hold_am_idx", int'(ifa.o_am_idx), prev_ai);
                end
                if (!first) begin
                    chk_i("pulse_quiet", int'({ifa.o_period_start, ifa.o_underrun}), 0);
                end else if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_block act=%h", ifa.o_block);
                end else begin
                    e = expq[0];
                    chk_i("period_start", int'(ifa.o_period_start), int'(e.ps));
                    chk_i("underrun", int'(ifa.o_underrun), int'(e.ur));
                    chk_i("next_block_idx", int'(ifa.o_block_idx), (e.slot + 1) % NA);
                    chk_i("next_am_idx", int'(ifa.o_am_idx), (e.slot < KA - 1) ? e.slot + 1 : 0);
                end
                if (ifa.o_block_valid && ifa.i_block_ready && expq.size() > 0) begin
                    e = expq.pop_front();
                    chk_blk("block", ifa.o_block, e.blk);
                    chk_i("is_am", int'(ifa.o_is_am), int'(e.is_am));
                end
                prev_v = ifa.o_block_valid;
                prev_r = ifa.i_block_ready;
                prev_blk = ifa.o_block;
                prev_bi = int'(ifa.o_block_idx);
                prev_ai = int'(ifa.o_am_idx);
            end
        end
    end

    initial begin
        int nb, expb, s;
        nb = 0; expb = 0;
        forever begin
            @(negedge clk);
            if (rst && chk_b && ifb.o_block_valid) begin
                s = nb % NB;
                if (s < KA) begin
                    chk_blk("b_am_block", ifb.o_block, am_pat(s));
                end else begin
                    chk_blk("b_data_block", ifb.o_block, pay(expb));
                    expb++;
                end
                chk_i("b_is_am", int'(ifb.o_is_am), int'(s < KA));
                chk_i("b_period_start", int'(ifb.o_period_start), int'(s == 0));
                chk_i("b_next_block_idx", int'(ifb.o_block_idx), (s + 1) % NB);
                nb++;
            end
        end
    end

    task automatic wait_until_idx(input int pc, input int idx, input string name);
        int n;
        n = 0;
        while (!(pcount == pc && int'(ifa.o_block_idx) == idx && ifa.o_block_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            total++;
            bad++;
            $display("FAIL timeout_%s act=%0d exp=%0d", name, int'(ifa.o_block_idx), idx);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((expq.size() != 0 || ifa.o_block_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            total++;
            bad++;
            $display("FAIL timeout_%s act=%0d exp=0", name, expq.size());
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk_blk({tag, "_block"}, ifa.o_block, '0);
        chk_i({tag, "_valid"}, int'(ifa.o_block_valid), 0);
        chk_i({tag, "_is_am"}, int'(ifa.o_is_am), 0);
        chk_i({tag, "_am_idx"}, int'(ifa.o_am_idx), 0);
        chk_i({tag, "_block_idx"}, int'(ifa.o_block_idx), 0);
        chk_i({tag, "_pulses"}, int'({ifa.o_period_start, ifa.o_underrun}), 0);
        chk_i({tag, "_data_ready"}, int'(ifa.o_data_ready), 0);
    endtask

    initial begin
        ifa.i_enable = 1'b0;
        ifb.i_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(negedge clk);
        chk_i("idle_no_load", int'(ifa.o_block_valid), 0);

        push_period(1'b1);
        push_period(1'b0);
        push_period(1'b0);
        @(posedge clk);
        #1;
        ifa.i_enable = 1'b1;
        ifb.i_enable = 1'b1;
        chk_b = 1'b1;

        wait_until_idx(3, 20, "enable_drop");
        @(posedge clk);
        #1 ifa.i_enable = 1'b0;
        wait_drain("graceful_stop");
        repeat (5) begin
            @(negedge clk);
            chk_i("stopped_data_ready", int'(ifa.o_data_ready), 0);
            chk_i("stopped_valid", int'(ifa.o_block_valid), 0);
            chk_i("stopped_block_idx", int'(ifa.o_block_idx), 0);
        end
        chk_b = 1'b0;
        ifb.i_enable = 1'b0;

        push_period(1'b0);
        @(posedge clk);
        #1 ifa.i_enable = 1'b1;
        wait_until_idx(4, 2, "stall_point");
        stall = 5;
        wait_until_idx(4, 25, "reset_point");
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk_all_zero("async_reset");
        expq.delete();
        exp_pay = src_cnt;
        ifa.i_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        push_period(1'b0);
        @(posedge clk);
        #1 ifa.i_enable = 1'b1;
        wait_until_idx(5, 5, "restart");
        @(posedge clk);
        #1 ifa.i_enable = 1'b0;
        wait_drain("restart_drain");
        chk_i("periods_started", pcount, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/am_insertion_scheduler.md
AM_INSERTION_SCHEDULER -- requirements
Module: am_insertion_scheduler

Interface
REQ-001 SHALL have parameter BITS_BLOCK, default 257, meaning the width of one transcoded block in bits.
REQ-002 SHALL have parameter MAX_BLOCKS_AM, default 40, meaning the number of blocks per AM period, AM blocks included.
REQ-003 SHALL have parameter AM_BLOCKS, default 4, meaning the number of AM blocks at the start of each period (4 x 257 = 1028 mapped AM bits).
REQ-004 SHALL have one clock and an asynchronous, active-low reset, with ports named as in the codebase, listed first:
- clk  in  1  sole clock.
- rst  in  1  asynchronous active-low reset.
REQ-005 SHALL have the remaining ports (name, direction, width, meaning):
- i_enable  in  1  run request.
- i_am_block  in  BITS_BLOCK  AM slice selected by o_am_idx; combinational from the AM mapper.
- i_data  in  BITS_BLOCK  payload block.
- i_data_valid  in  1  payload available.
- o_data_ready  out  1  payload accepted this cycle.
- o_block  out  BITS_BLOCK  scheduled output block.
- o_block_valid  out  1  o_block holds a block.
- i_block_ready  in  1  downstream accepts.
- o_am_idx  out  clog2(AM_BLOCKS)  AM slice to present.
- o_block_idx  out  clog2(MAX_BLOCKS_AM)  position of the block next loaded.
- o_is_am  out  1  o_block is an AM block.
- o_period_start  out  1  one-cycle pulse when AM block 0 loads.
- o_underrun  out  1  one-cycle pulse when a fill block loads.

Function
REQ-006 SHALL implement FSM states IDLE, AM, DATA; the state SHALL be IDLE after reset.
REQ-007 SHALL define load = (state != IDLE) && (!o_block_valid || i_block_ready); the output register SHALL update only on load; o_block_valid SHALL be set on load and cleared when i_block_ready is high with no load.
REQ-008 SHALL transition IDLE->AM in the cycle after i_enable is sampled high, with o_block_idx=0 and o_am_idx=0.
REQ-009 SHALL, in state AM on each load, capture i_am_block, set o_is_am=1, and increment o_am_idx and o_block_idx.
REQ-010 SHALL go AM->DATA on the load of block AM_BLOCKS-1.
REQ-011 SHALL, in state DATA, drive o_data_ready = load && i_data_valid; on load with valid data it SHALL capture i_data and set o_is_am=0.
REQ-012 SHALL, in state DATA on load with i_data_valid low, load an all-ones fill block, pulse o_underrun, and still advance o_block_idx, so the AM spacing stays fixed.
REQ-013 SHALL, on the load at o_block_idx=MAX_BLOCKS_AM-1, wrap o_block_idx to 0 and o_am_idx to 0, then go to AM if i_enable=1, else to IDLE.
REQ-014 SHALL ignore i_enable deassertion mid-period; the period always completes (graceful stop).
REQ-015 SHALL keep o_block, o_block_idx and o_am_idx stable while o_block_valid=1 and i_block_ready=0 (backpressure hold, no data loss).
REQ-016 SHALL deliver in IDLE any pending o_block; no new load occurs in IDLE.
REQ-017 SHALL pulse o_period_start in the cycle following the load of AM block 0.
REQ-018 SHALL give one-cycle latency from load to o_block/o_block_valid; throughput SHALL be one block per cycle under continuous i_block_ready.

Reset
REQ-019 SHALL on rst low asynchronously force: state=IDLE; o_block=0; o_block_valid=0; o_is_am=0; o_am_idx=0; o_block_idx=0; o_period_start=0; o_underrun=0; o_data_ready=0.
REQ-020 SHALL abort a period immediately on mid-operation reset; the next period after release SHALL start at AM block 0.

Structure
REQ-021 SHALL place in a shared package the FSM state enum and the BITS_BLOCK, MAX_BLOCKS_AM and AM_BLOCKS defaults, shared with the AM mapper and lane distributor.
REQ-022 SHALL keep AM mapping outside this block; one sub-module, am_period_counter (block and AM index counters with wrap), is natural.

Verification
REQ-023 SHALL cover these directed scenarios:
- Enable=1, data always valid, ready=1 -> per 40-cycle period: 4 blocks with o_is_am=1 (am_idx 0..3), then 36 data blocks in order; o_period_start every 40 loads.
- Data valid low during block_idx 10..12 -> three all-ones blocks, three o_underrun pulses; AM block 0 still at load 40.
- i_block_ready low for 5 cycles at block_idx 2 -> o_block and indices frozen; no data dropped or duplicated.
- i_enable dropped at block_idx 20 -> blocks 20..39 still emitted, then IDLE; o_data_ready=0 afterwards.
- rst asserted at block_idx 25 -> all outputs 0 asynchronously; after release and enable, first block is AM idx 0.
- AM_BLOCKS=4, MAX_BLOCKS_AM=8 build -> 4 AM and 4 data blocks per period; wrap is correct.
